// File: rtl/xc_malu_pkg.sv
// Shared MALU definitions: operand widths, iteration count and sequencer state encoding.
package xc_malu_pkg;

    localparam int unsigned XC_MALU_XLEN      = 32;
    localparam int unsigned XC_MALU_PLEN      = 2 * XC_MALU_XLEN;
    localparam int unsigned XC_MALU_MUL_ITERS = 32;
    localparam int unsigned XC_MALU_CNTW      = 6;

    localparam logic [1:0] XC_MALU_IDLE = 2'd0;
    localparam logic [1:0] XC_MALU_RUN  = 2'd1;
    localparam logic [1:0] XC_MALU_SIGN = 2'd2;
    localparam logic [1:0] XC_MALU_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = XC_MALU_IDLE,
        ST_RUN  = XC_MALU_RUN,
        ST_SIGN = XC_MALU_SIGN,
        ST_DONE = XC_MALU_DONE
    } malu_state_t;

endpackage

// File: rtl/xc_malu_mul_seq_if.sv
// Request/response bundle between a MALU requester and the multiply sequencer.
interface xc_malu_mul_seq_if;
    import xc_malu_pkg::*;

    logic [XC_MALU_XLEN-1:0] rs1;
    logic [XC_MALU_XLEN-1:0] rs2;
    logic                    valid;
    logic                    op_signed;
    logic                    flush;
    logic [XC_MALU_PLEN-1:0] result;
    logic                    ready;
    logic                    busy;

    modport master (
        output rs1, rs2, valid, op_signed, flush,
        input  result, ready, busy
    );

    modport slave (
        input  rs1, rs2, valid, op_signed, flush,
        output result, ready, busy
    );

endinterface

// File: rtl/xc_malu_mul_step.sv
// One shift-and-add iteration: add the multiplicand, shifted to the current bit weight, when the multiplier bit is set.
module xc_malu_mul_step
    import xc_malu_pkg::*;
(
    input  logic [XC_MALU_PLEN-1:0] acc,
    input  logic [XC_MALU_XLEN-1:0] mcand,
    input  logic                    mplier_lsb,
    input  logic [XC_MALU_CNTW-1:0] count,
    output logic [XC_MALU_PLEN-1:0] acc_next_c
);

    logic [XC_MALU_PLEN-1:0] partial;

    // Partial product for this bit position; it never exceeds 2^63 so the sum cannot overflow.
    always_comb begin
        partial    = XC_MALU_PLEN'(mcand) << count;
        acc_next_c = mplier_lsb ? (acc + partial) : acc;
    end

endmodule

// File: rtl/xc_malu_mul_seq.sv
// Iterative radix-2 multiplier sequencer: fixed 34-cycle latency for signed and unsigned 32x32->64.
module xc_malu_mul_seq
    import xc_malu_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    xc_malu_mul_seq_if.slave   bus
);

    malu_state_t             state, state_n;
    logic [XC_MALU_PLEN-1:0] acc, acc_n;
    logic [XC_MALU_XLEN-1:0] mcand, mcand_n;
    logic [XC_MALU_XLEN-1:0] mplier, mplier_n;
    logic [XC_MALU_CNTW-1:0] count, count_n;
    logic                    neg, neg_n;
    logic [XC_MALU_PLEN-1:0] result_q, result_n;
    logic                    ready_q, ready_n;
    logic                    busy_q, busy_n;
    logic [XC_MALU_PLEN-1:0] step_acc;

    xc_malu_mul_step u_step (
        .acc        (acc),
        .mcand      (mcand),
        .mplier_lsb (mplier[0]),
        .count      (count),
        .acc_next_c (step_acc)
    );

    assign bus.result = result_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;

    // State and datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            neg      <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            mcand    <= mcand_n;
            mplier   <= mplier_n;
            count    <= count_n;
            neg      <= neg_n;
            result_q <= result_n;
            ready_q  <= ready_n;
            busy_q   <= busy_n;
        end
    end

    // Next-state, datapath update and registered-output precompute.
    always_comb begin
        state_n  = state;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        count_n  = count;
        neg_n    = neg;
        result_n = result_q;
        ready_n  = 1'b0;
        busy_n   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.valid && !bus.flush) begin
                    mcand_n  = (bus.op_signed && bus.rs1[XC_MALU_XLEN-1]) ? -bus.rs1 : bus.rs1;
                    mplier_n = (bus.op_signed && bus.rs2[XC_MALU_XLEN-1]) ? -bus.rs2 : bus.rs2;
                    neg_n    = bus.op_signed & (bus.rs1[XC_MALU_XLEN-1] ^ bus.rs2[XC_MALU_XLEN-1]);
                    acc_n    = '0;
                    count_n  = '0;
                    state_n  = ST_RUN;
                end
            end
            ST_RUN: begin
                acc_n    = step_acc;
                mplier_n = mplier >> 1;
                count_n  = count + XC_MALU_CNTW'(1);
                if (count == XC_MALU_CNTW'(XC_MALU_MUL_ITERS - 1)) begin
                    state_n = ST_SIGN;
                end
            end
            ST_SIGN: begin
                if (neg) begin
                    acc_n = ~acc + XC_MALU_PLEN'(1);
                end
                state_n = ST_DONE;
            end
            ST_DONE: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        // Abort wins over everything except reset; result keeps its last completed value.
        if (bus.flush) begin
            state_n = ST_IDLE;
        end

        ready_n = (state_n == ST_DONE);
        busy_n  = (state_n != ST_IDLE);
        if (state_n == ST_DONE) begin
            result_n = acc_n;
        end
    end

endmodule

// File: tb/tb_xc_malu_mul_seq.sv
// Directed and randomized checks of the multiply sequencer against an arithmetic reference.
module tb_xc_malu_mul_seq;
    import xc_malu_pkg::*;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    xc_malu_mul_seq_if bus ();

    xc_malu_mul_seq dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Reference product from plain integer arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Issue one request from the current cycle; lead=1 when the sequencer is still in DONE.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int lead,
                          input bit keep, input bit scramble);
        logic [63:0] prev;
        int          got_n;
        prev  = bus.result;
        got_n = -1;
        bus.rs1       = a;
        bus.rs2       = b;
        bus.op_signed = s;
        bus.valid     = 1'b1;
        for (int n = 0; n < 40 + lead; n++) begin
            step();
            if (n == lead) check({tag, " busy_rise"}, 64'(bus.busy), 64'd1);
            if (scramble && n == lead + 10) begin
                bus.rs1       = $urandom;
                bus.rs2       = $urandom;
                bus.op_signed = 1'($urandom_range(0, 1));
            end
            if (n == lead + 20) check({tag, " result_hold"}, bus.result, prev);
            if (bus.ready) begin
                got_n = n;
                break;
            end
        end
        check({tag, " latency"}, 64'(got_n), 64'(33 + lead));
        check({tag, " result"}, bus.result, exp);
        if (!keep) bus.valid = 1'b0;
    endtask

    task automatic idle_check(input string tag, input logic [63:0] exp);
        step();
        check({tag, " ready_drop"}, 64'(bus.ready), 64'd0);
        check({tag, " busy_drop"}, 64'(bus.busy), 64'd0);
        check({tag, " result_keep"}, bus.result, exp);
    endtask

    initial begin
        logic [31:0] a, b;
        logic        s;
        logic [63:0] prev;
        logic [63:0] exp1;
        bit          saw;
        int          c1;

        reset         = 1'b1;
        bus.valid     = 1'b0;
        bus.flush     = 1'b0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.op_signed = 1'b0;
        #12;
        check("reset result", bus.result, 64'd0);
        check("reset ready", 64'(bus.ready), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        step();

        run_op("u3x5", 32'd3, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 0, 1'b0, 1'b0);
        idle_check("u3x5", 64'h0000_0000_0000_000F);
        run_op("umax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, 1'b0, 1'b0);
        idle_check("umax", 64'hFFFF_FFFE_0000_0001);
        run_op("sm3x7", 32'hFFFF_FFFD, 32'h0000_0007, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB, 0, 1'b0, 1'b0);
        idle_check("sm3x7", 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("smin2", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, 1'b0, 1'b0);
        idle_check("smin2", 64'h4000_0000_0000_0000);

        // Flush in the middle of RUN.
        prev          = bus.result;
        bus.rs1       = 32'd9;
        bus.rs2       = 32'd9;
        bus.op_signed = 1'b0;
        bus.valid     = 1'b1;
        for (int n = 0; n < 10; n++) step();
        bus.flush = 1'b1;
        step();
        check("flush busy", 64'(bus.busy), 64'd0);
        check("flush ready", 64'(bus.ready), 64'd0);
        check("flush result", bus.result, prev);
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        saw = 1'b0;
        for (int n = 0; n < 40; n++) begin
            step();
            saw |= bus.ready;
        end
        check("flush no_ready", 64'(saw), 64'd0);
        run_op("f6x7", 32'd6, 32'd7, 1'b0, 64'h0000_0000_0000_002A, 0, 1'b0, 1'b0);
        idle_check("f6x7", 64'h0000_0000_0000_002A);

        // Flush together with valid in IDLE must not start.
        bus.flush = 1'b1;
        bus.valid = 1'b1;
        step();
        step();
        check("flush_valid busy", 64'(bus.busy), 64'd0);
        bus.flush = 1'b0;
        bus.valid = 1'b0;
        step();

        // Asynchronous reset mid-RUN.
        bus.rs1   = 32'd5;
        bus.rs2   = 32'd5;
        bus.valid = 1'b1;
        for (int n = 0; n < 20; n++) step();
        #3;
        reset = 1'b1;
        #1;
        check("async_rst result", bus.result, 64'd0);
        check("async_rst ready", 64'(bus.ready), 64'd0);
        check("async_rst busy", 64'(bus.busy), 64'd0);
        bus.valid = 1'b0;
        step();
        step();
        @(negedge clock);
        reset = 1'b0;
        step();
        check("post_rst busy", 64'(bus.busy), 64'd0);
        run_op("sm1xm1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, 0, 1'b0, 1'b0);
        idle_check("sm1xm1", 64'h0000_0000_0000_0001);

        // Back-to-back with valid held through ready and operands scrambled mid-RUN.
        a = $urandom;
        b = $urandom;
        exp1 = ref_mul(a, b, 1'b0);
        run_op("b2b_first", a, b, 1'b0, exp1, 0, 1'b1, 1'b1);
        c1 = cyc;
        a = $urandom;
        b = $urandom;
        run_op("b2b_second", a, b, 1'b1, ref_mul(a, b, 1'b1), 1, 1'b0, 1'b1);
        check("b2b interval", 64'(cyc - c1), 64'd35);
        idle_check("b2b_second", ref_mul(a, b, 1'b1));

        // Randomized operands and signedness.
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            if (i == 2) a = 32'h8000_0000;
            if (i == 5) b = 32'd0;
            run_op("rand", a, b, s, ref_mul(a, b, s), 0, 1'b0, i[0]);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xc_malu_mul_seq.md
# xc_malu_mul_seq

Iterative radix-2 shift-and-add multiplier sequencer for the xcrypto MALU. It is the multiply counterpart to the iterative divide/remainder path: the divider reduces a 64-bit accumulator to a quotient, and this block builds a 64-bit product up from two 32-bit operands one bit per cycle. It sits beside the divider under the MALU top and shares its request convention: `valid` is held until `ready`, and `ready` is a one-cycle strobe. Signed and unsigned operation give fixed, operand-independent latency, which suits constant-time cryptographic code.

## Interface
Parameters:
- none (width fixed at 32x32->64).

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rs1`  in  32  multiplicand; sampled only at operation start.
- `rs2`  in  32  multiplier; sampled only at operation start.
- `valid`  in  1  request; held high by the requester until `ready`.
- `op_signed`  in  1  1 = both operands are two's complement; 0 = both unsigned. Sampled at start.
- `flush`  in  1  abort any operation; highest priority after reset.
- `result`  out  64  product; valid while `ready` = 1 and held until the next completion.
- `ready`  out  1  one-cycle completion strobe.
- `busy`  out  1  high in RUN, SIGN and DONE.

## Operation
- FSM states: IDLE, RUN, SIGN, DONE.
- **IDLE**
  - If `valid` and not `flush`:
    - capture `|rs1|` into `mcand[31:0]` and `|rs2|` into `mplier[31:0]`;
    - magnitude is taken only when `op_signed` = 1;
    - store `neg = op_signed & (rs1[31] ^ rs2[31])`;
    - clear `acc[63:0]` and `count[5:0]`;
    - go to RUN.
  - Magnitude of 0x80000000 is 2^31, held as unsigned 32-bit with no overflow.
- **RUN**, each cycle:
  - if `mplier[0]`, then `acc += mcand << count` (64-bit, no overflow is possible);
  - `mplier >>= 1`; `count++`;
  - after the update with `count` = 31, go to SIGN. That is exactly 32 RUN cycles, with no early exit when `mplier` = 0.
- **SIGN**
  - If `neg`, then `acc = ~acc + 1`; otherwise `acc` is unchanged. One cycle in both cases.
  - Go to DONE.
- **DONE**
  - `ready` = 1 and `result` = `acc` for this cycle.
  - Go to IDLE.
  - The requester drops `valid` in the cycle after `ready`. A `valid` still high in the following IDLE cycle starts a new operation; this is legal back-to-back use.
- **`flush`**
  - In any state: next state is IDLE and `ready` is not asserted.
  - `result` keeps its last completed value.
  - `flush` together with `valid` in IDLE: no start.
- **`reset`**
  - Asynchronous: state=IDLE, `result`=0, `ready`=0, `busy`=0, `acc`/`mcand`/`mplier`/`count`/`neg` = 0.
  - Reset mid-RUN abandons the operation with no `ready`.
- **Input changes after start**
  - `rs1`/`rs2`/`op_signed` changing after start has no effect.

## Timing
- Start edge: the edge at the end of cycle T, where T is the cycle in which IDLE sees `valid`.
- Cycle map: RUN in T+1..T+32, SIGN in T+33, DONE in T+34.
- `ready` is high in cycle T+34 only: latency 34 cycles, identical for every operand and signedness.
- `busy` rises in T+1 and falls in T+35.
- Issue interval: 35 cycles.
- `result` updates on the edge entering DONE and is stable from T+34 until the next DONE.
- No combinational path from any input to any output.

## Structure
- Package `xc_malu_pkg` holds:
  - state encoding (2-bit localparams: IDLE=0, RUN=1, SIGN=2, DONE=3);
  - `XC_MALU_XLEN` = 32;
  - the RUN iteration count of 32.
  - The divider uses the same package.
- One sub-module, `xc_malu_mul_step`: combinational single-iteration step.
  - Inputs: `acc`, `mcand`, `mplier[0]`, `count`.
  - Output: next `acc`.
  - The FSM holds all registers.

## Test plan
- Unsigned 3 x 5: `valid` at T, `op_signed`=0 -> `ready` only at T+34, `result` = 0x000000000000000F.
- Unsigned 0xFFFFFFFF x 0xFFFFFFFF -> `result` = 0xFFFFFFFE00000001 at T+34.
- Signed -3 x 7 (0xFFFFFFFD, 0x00000007) -> 0xFFFFFFFFFFFFFFEB; signed 0x80000000 x 0x80000000 -> 0x4000000000000000.
- `flush` at T+10 -> no `ready`, `busy`=0 from T+11, `result` unchanged; a following 6 x 7 request -> 0x2A exactly 34 cycles after its start.
- `reset` asserted asynchronously at T+20 -> all outputs 0 immediately, FSM IDLE; after release, -1 x -1 signed -> 0x0000000000000001.
- Back-to-back: `valid` held through `ready` -> second operation starts in the cycle after DONE; `ready` pulses 35 cycles apart, and `rs1`/`rs2` changes mid-RUN do not alter either result.
